long_to_double: RTL and testbench
=================================

LONG_TO_DOUBLE -- requirements
Module: long_to_double

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 64 bits.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
REQ-003 The block SHALL have these data and handshake ports:
- input_a  input  64  two's-complement signed integer to convert.
- input_a_stb  input  1  upstream asserts when input_a is valid; stimulus source is the file reader.
- input_a_ack  output  1  asserted while the block is ready to accept input_a.
- output_z  output  64  IEEE-754 binary64 result.
- output_z_stb  output  1  asserted while output_z is valid.
- output_z_ack  input  1  downstream accepts output_z.

Function
REQ-004 Input transfer SHALL occur on a rising edge where input_a_stb and input_a_ack are both 1; output transfer SHALL occur on an edge where output_z_stb and output_z_ack are both 1.
REQ-005 The FSM SHALL have exactly six states: GET_A, CONVERT_0, CONVERT_1, ROUND, PACK, PUT_Z.
REQ-006 GET_A: input_a_ack=1. On input transfer, latch input_a, drive ack to 0, and go to CONVERT_0.
REQ-007 CONVERT_0, zero input: if the latched value is 0, set output_z=0x0000000000000000, set output_z_stb=1, and go to PUT_Z. The result is +0 and is never -0.
REQ-008 CONVERT_0, nonzero input:
- sign = a[63].
- magnitude = sign ? (0 - a) mod 2^64 : a; 0x8000000000000000 therefore yields magnitude 2^63.
- exponent = 63.
- Go to CONVERT_1.
REQ-009 CONVERT_1: while magnitude[63]=0, shift magnitude left by one bit and decrement exponent, one step per cycle. When magnitude[63]=1, go to ROUND.
REQ-010 ROUND: take mantissa=magnitude[63:11] (53 bits), guard=magnitude[10], round=magnitude[9], sticky=OR(magnitude[8:0]).
- If guard AND (round OR sticky OR mantissa[0]), increment mantissa (round-to-nearest-even).
- If the increment carries out of 53 bits, set mantissa=2^52 and increment exponent.
- Go to PACK.
REQ-011 PACK: output_z = {sign, exponent+1023 (11 bits), mantissa[51:0]}; set output_z_stb=1 and go to PUT_Z. Overflow, denormal and NaN results are impossible and SHALL NOT be handled.
REQ-012 PUT_Z: hold output_z and output_z_stb stable until output transfer. On transfer, drive output_z_stb to 0 and go to GET_A.
REQ-013 output_z_stb SHALL NOT depend combinationally on output_z_ack. input_a_ack SHALL NOT depend combinationally on input_a_stb.
REQ-014 Latency SHALL be measured in rising edges from the input-transfer edge to the edge that sets output_z_stb=1:
- nonzero input: lz+4, where lz = leading zeros of the magnitude (0..63).
- zero input: 1.
REQ-015 At most one value SHALL be in flight. input_a_ack SHALL be 0 in every state other than GET_A.
REQ-016 After an output transfer, input_a_ack SHALL be 1 in the next cycle, with no idle cycle beyond the GET_A state.

Reset
REQ-017 While rst=1, the block SHALL immediately (asynchronously) force:
- state = GET_A.
- input_a_ack = 0 while rst is held.
- output_z_stb = 0.
- output_z = 0.
REQ-018 On the first edge after rst deasserts, input_a_ack SHALL become 1.
REQ-019 Reset mid-conversion or in PUT_Z SHALL discard the in-flight value; no partial result SHALL be emitted.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- input 0x0000000000000001, output_z_ack tied to 1 -> output_z=0x3FF0000000000000; stb rises 67 edges after input transfer.
- input 0xFFFFFFFFFFFFFFFF (-1) -> 0xBFF0000000000000. Input 0x0000000000000000 -> 0x0000000000000000, stb rises 1 edge after input transfer.
- input 0x7FFFFFFFFFFFFFFF -> 0x43E0000000000000 (rounding carry bumps exponent). Input 0x8000000000000000 -> 0xC3E0000000000000, latency 4.
- ties: 0x0020000000000001 -> 0x4340000000000000 (round to even, down); 0x0020000000000003 -> 0x4340000000000002 (round to even, up).
- backpressure: hold output_z_ack=0 for 10 cycles in PUT_Z -> output_z and stb stable, input_a_ack=0 throughout; result transfers on the first ack edge.
- reset during CONVERT_1 -> stb and ack drop immediately; the next input, 5 -> 0x4014000000000000 with no stale output.

Source files
------------

// File: rtl/long_to_double.sv
// Converts a 64-bit two's-complement integer to IEEE-754 binary64.
// Iterative normalise, round-to-nearest-even, one value in flight.
module long_to_double (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   output logic [63:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack
);

   typedef enum logic [2:0] {
      GET_A,
      CONVERT_0,
      CONVERT_1,
      ROUND,
      PACK,
      PUT_Z
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] a_q, a_d;
   logic [63:0] mag_q, mag_d;
   logic [52:0] mant_q, mant_d;
   logic [10:0] exp_q, exp_d;
   logic        sign_q, sign_d;
   logic [63:0] z_q, z_d;
   logic        zstb_q, zstb_d;
   logic        ack_q, ack_d;

   logic        guard, rnd, sticky, round_up;
   logic [53:0] mant_inc;

   assign guard    = mag_q[10];
   assign rnd      = mag_q[9];
   assign sticky   = |mag_q[8:0];
   assign round_up = guard & (rnd | sticky | mag_q[11]);
   assign mant_inc = {1'b0, mag_q[63:11]} + 54'(round_up);

   assign input_a_ack  = ack_q;
   assign output_z     = z_q;
   assign output_z_stb = zstb_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= GET_A;
         a_q     <= '0;
         mag_q   <= '0;
         mant_q  <= '0;
         exp_q   <= '0;
         sign_q  <= 1'b0;
         z_q     <= '0;
         zstb_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         mag_q   <= mag_d;
         mant_q  <= mant_d;
         exp_q   <= exp_d;
         sign_q  <= sign_d;
         z_q     <= z_d;
         zstb_q  <= zstb_d;
         ack_q   <= ack_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      mag_d   = mag_q;
      mant_d  = mant_q;
      exp_d   = exp_q;
      sign_d  = sign_q;
      z_d     = z_q;
      zstb_d  = zstb_q;
      ack_d   = ack_q;
      unique case (state_q)
         GET_A: begin
            if (input_a_stb && ack_q) begin
               a_d     = input_a;
               ack_d   = 1'b0;
               state_d = CONVERT_0;
            end else begin
               ack_d = 1'b1;
            end
         end
         CONVERT_0: begin
            if (a_q == 64'd0) begin
               z_d     = 64'd0;
               zstb_d  = 1'b1;
               state_d = PUT_Z;
            end else begin
               sign_d  = a_q[63];
               mag_d   = a_q[63] ? (64'd0 - a_q) : a_q;
               exp_d   = 11'd63;
               state_d = CONVERT_1;
            end
         end
         CONVERT_1: begin
            if (mag_q[63]) begin
               state_d = ROUND;
            end else begin
               mag_d = mag_q << 1;
               exp_d = exp_q - 11'd1;
            end
         end
         ROUND: begin
            // carry out of 53 bits means the mantissa rolled to 2.0
            if (mant_inc[53]) begin
               mant_d = 53'h10_0000_0000_0000;
               exp_d  = exp_q + 11'd1;
            end else begin
               mant_d = mant_inc[52:0];
            end
            state_d = PACK;
         end
         PACK: begin
            z_d     = {sign_q, exp_q + 11'd1023, mant_q[51:0]};
            zstb_d  = 1'b1;
            state_d = PUT_Z;
         end
         PUT_Z: begin
            if (output_z_ack) begin
               zstb_d  = 1'b0;
               ack_d   = 1'b1;
               state_d = GET_A;
            end
         end
         default: state_d = GET_A;
      endcase
   end

endmodule

// File: tb/tb_long_to_double.sv
// Directed bench for long_to_double: values, latency, backpressure
// and reset behaviour against hand-computed results.
module tb_long_to_double;

   logic        clk;
   logic        rst;
   logic [63:0] input_a;
   logic        input_a_stb;
   logic        input_a_ack;
   logic [63:0] output_z;
   logic        output_z_stb;
   logic        output_z_ack;

   int n_cmp = 0;
   int n_err = 0;

   long_to_double dut (
      .clk          (clk),
      .rst          (rst),
      .input_a      (input_a),
      .input_a_stb  (input_a_stb),
      .input_a_ack  (input_a_ack),
      .output_z     (output_z),
      .output_z_stb (output_z_stb),
      .output_z_ack (output_z_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [63:0] a);
      int w;
      w = 0;
      @(negedge clk);
      while (!input_a_ack && w < 20) begin
         @(negedge clk);
         w++;
      end
      input_a     = a;
      input_a_stb = 1'b1;
      @(posedge clk);
      #1 input_a_stb = 1'b0;
   endtask

   task automatic wait_stb(output int lat);
      lat = 0;
      while (!output_z_stb && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run(input string tag, input logic [63:0] a,
                      input logic [63:0] z, input int lat_exp);
      int lat;
      send(a);
      wait_stb(lat);
      chk({tag, "_stb"}, 64'(output_z_stb), 64'd1);
      chk({tag, "_lat"}, 64'(lat), 64'(lat_exp));
      chk({tag, "_z"}, output_z, z);
      @(posedge clk);
      #1;
      chk({tag, "_ack_after"}, 64'(input_a_ack), 64'd1);
      chk({tag, "_stb_after"}, 64'(output_z_stb), 64'd0);
   endtask

   initial begin
      int lat;
      int seen;
      rst          = 1'b1;
      input_a      = '0;
      input_a_stb  = 1'b0;
      output_z_ack = 1'b1;
      #2;
      chk("rst_ack", 64'(input_a_ack), 64'd0);
      chk("rst_stb", 64'(output_z_stb), 64'd0);
      chk("rst_z", output_z, 64'd0);
      repeat (2) @(posedge clk);
      #1 chk("rst_ack_held", 64'(input_a_ack), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 chk("rst_ack_first", 64'(input_a_ack), 64'd1);

      run("one", 64'h0000_0000_0000_0001, 64'h3FF0_0000_0000_0000, 67);
      run("neg1", 64'hFFFF_FFFF_FFFF_FFFF, 64'hBFF0_0000_0000_0000, 67);
      run("zero", 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1);
      run("maxpos", 64'h7FFF_FFFF_FFFF_FFFF, 64'h43E0_0000_0000_0000, 5);
      run("minneg", 64'h8000_0000_0000_0000, 64'hC3E0_0000_0000_0000, 4);
      run("tie_dn", 64'h0020_0000_0000_0001, 64'h4340_0000_0000_0000, 14);
      run("tie_up", 64'h0020_0000_0000_0003, 64'h4340_0000_0000_0002, 14);

      // backpressure in PUT_Z
      output_z_ack = 1'b0;
      send(64'd5);
      wait_stb(lat);
      chk("bp_lat", 64'(lat), 64'd65);
      chk("bp_z", output_z, 64'h4014_0000_0000_0000);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("bp_hold_stb", 64'(output_z_stb), 64'd1);
         chk("bp_hold_z", output_z, 64'h4014_0000_0000_0000);
         chk("bp_hold_ack", 64'(input_a_ack), 64'd0);
      end
      output_z_ack = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_xfer_stb", 64'(output_z_stb), 64'd0);
      chk("bp_xfer_ack", 64'(input_a_ack), 64'd1);

      // reset while normalising a long shift
      send(64'd1);
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_stb", 64'(output_z_stb), 64'd0);
      chk("mid_rst_ack", 64'(input_a_ack), 64'd0);
      chk("mid_rst_z", output_z, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 chk("mid_rst_ack_first", 64'(input_a_ack), 64'd1);
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         #1;
         if (output_z_stb) seen++;
      end
      chk("mid_rst_no_stale", 64'(seen), 64'd0);
      run("post_rst", 64'd5, 64'h4014_0000_0000_0000, 65);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
